// File: rtl/etroc_frame_gearbox.sv
// ETROC frame gearbox: strips trigger bits from the per-clk40 link word, packs the payload
// into a circular bit buffer and emits bit-slip-aligned FRAME_W-bit frames.
module etroc_frame_gearbox #(
    parameter int               IN_W        = 32,
    parameter int               FRAME_W     = 40,
    parameter int               BUF_W       = 256,
    parameter int               HDR_W       = 16,
    parameter logic [HDR_W-1:0] HDR_PATTERN = 16'h3C5C,
    parameter int               LOCK_CNT    = 4,
    parameter int               MAX_GAP     = 64,
    parameter int               UNLOCK_CNT  = 3
) (
    input  logic               clk40,
    input  logic               reset,
    input  logic [1:0]         dataRate,
    input  logic [4:0]         trigDataSize,
    input  logic [IN_W-1:0]    din,
    input  logic               clrError,
    input  logic               autoAlign,
    output logic [FRAME_W-1:0] dout,
    output logic               doutValid,
    output logic               aligned,
    output logic [1:0]         state,
    output logic [7:0]         slipCount,
    output logic               configError,
    output logic               lockLost
);

    localparam int PTR_W  = $clog2(BUF_W);
    localparam int FILL_W = PTR_W + 1;
    localparam int WID_W  = $clog2(IN_W + 1);
    localparam int HCNT_W = $clog2(LOCK_CNT + 1);
    localparam int GAP_W  = $clog2(MAX_GAP + 1);
    localparam int VIOL_W = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              stateQ, stateNext;
    logic [IN_W-1:0]     dinQ;
    logic [WID_W-1:0]    wQ, wCur, rateW, trigExt;
    logic [1:0]          prevRate;
    logic [4:0]          prevTrig;
    logic [PTR_W-1:0]    wrPtr, rdPtr, rdBase;
    logic [FILL_W-1:0]   fill;
    logic                slipPend;
    logic [BUF_W-1:0]    bitBuf;
    logic [FRAME_W-1:0]  frame;
    logic [HCNT_W-1:0]   hdrCnt;
    logic [GAP_W-1:0]    gapCnt;
    logic [VIOL_W-1:0]   violCnt;
    logic                cfgBad, cfgChange, overflow, flush, emit, isHdr;
    logic                gapHit, hdrHit, violHit, slipSet, lockDrop;
    int                  fillSum;

    // Payload width of the word being presented now; zero when the trigger field eats it all.
    always_comb begin
        case (dataRate)
            2'b00:   rateW = WID_W'(8);
            2'b01:   rateW = WID_W'(16);
            default: rateW = WID_W'(32);
        endcase
        trigExt   = WID_W'(trigDataSize);
        cfgBad    = (trigExt >= rateW);
        wCur      = cfgBad ? '0 : rateW - trigExt;
        cfgChange = (dataRate != prevRate) || (trigDataSize != prevTrig);
    end

    // Read window starts after the pending slip bit; pointer arithmetic wraps modulo BUF_W.
    always_comb begin
        rdBase = rdPtr + PTR_W'(slipPend);
        frame  = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            frame[i] = bitBuf[rdBase + PTR_W'(i)];
        end
        isHdr    = (frame[FRAME_W-1 -: HDR_W] == HDR_PATTERN);
        emit     = (int'(fill) >= FRAME_W + int'(slipPend));
        fillSum  = int'(fill) + int'(wQ) - (emit ? FRAME_W + int'(slipPend) : 0);
        overflow = (fillSum > BUF_W - IN_W);
        flush    = cfgChange || overflow;
        gapHit   = (int'(gapCnt) + 1 >= MAX_GAP);
        hdrHit   = (int'(hdrCnt) + 1 >= LOCK_CNT);
        violHit  = (int'(violCnt) + 1 >= UNLOCK_CNT);
    end

    // doutValid is a one-cycle strobe with no backpressure; dout is meaningful while it is
    // high and holds its last frame until the next strobe.
    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            dinQ      <= '0;
            wQ        <= '0;
            prevRate  <= '0;
            prevTrig  <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fill      <= '0;
            slipPend  <= 1'b0;
            bitBuf    <= '0;
            dout      <= '0;
            doutValid <= 1'b0;
        end else begin
            dinQ     <= din;
            wQ       <= wCur;
            prevRate <= dataRate;
            prevTrig <= trigDataSize;
            if (flush) begin
                wrPtr     <= '0;
                rdPtr     <= '0;
                fill      <= '0;
                slipPend  <= 1'b0;
                doutValid <= 1'b0;
            end else begin
                for (int i = 0; i < IN_W; i++) begin
                    if (i < int'(wQ)) bitBuf[wrPtr + PTR_W'(i)] <= dinQ[i];
                end
                wrPtr     <= wrPtr + PTR_W'(wQ);
                fill      <= FILL_W'(fillSum);
                doutValid <= emit;
                if (emit) begin
                    dout     <= frame;
                    rdPtr    <= rdPtr + PTR_W'(FRAME_W) + PTR_W'(slipPend);
                    slipPend <= slipSet;
                end
            end
        end
    end

    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) stateQ <= HUNT;
        else        stateQ <= stateNext;
    end

    always_comb begin
        stateNext = stateQ;
        slipSet   = 1'b0;
        lockDrop  = 1'b0;
        if (flush) begin
            stateNext = HUNT;
        end else if (emit) begin
            case (stateQ)
                HUNT: begin
                    if (isHdr)          stateNext = VERIFY;
                    else if (autoAlign) slipSet   = 1'b1;
                end
                VERIFY: begin
                    if (isHdr && hdrHit)       stateNext = LOCKED;
                    else if (!isHdr && gapHit) stateNext = HUNT;
                end
                LOCKED: begin
                    if (!isHdr && gapHit && violHit) begin
                        stateNext = HUNT;
                        lockDrop  = 1'b1;
                    end
                end
                default: stateNext = HUNT;
            endcase
        end
    end

    always_comb begin
        state   = stateQ;
        aligned = (stateQ == LOCKED);
    end

    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            hdrCnt      <= '0;
            gapCnt      <= '0;
            violCnt     <= '0;
            slipCount   <= '0;
            configError <= 1'b0;
            lockLost    <= 1'b0;
        end else begin
            if (flush) begin
                hdrCnt  <= '0;
                gapCnt  <= '0;
                violCnt <= '0;
            end else if (emit) begin
                case (stateQ)
                    HUNT: begin
                        if (isHdr) begin
                            hdrCnt  <= HCNT_W'(1);
                            gapCnt  <= '0;
                            violCnt <= '0;
                        end else if (slipSet && slipCount != 8'hFF) begin
                            slipCount <= slipCount + 8'd1;
                        end
                    end
                    VERIFY: begin
                        if (isHdr) begin
                            hdrCnt <= hdrCnt + 1'b1;
                            gapCnt <= '0;
                        end else if (gapHit) begin
                            hdrCnt <= '0;
                            gapCnt <= '0;
                        end else begin
                            gapCnt <= gapCnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (isHdr) begin
                            gapCnt  <= '0;
                            violCnt <= '0;
                        end else if (gapHit) begin
                            gapCnt <= '0;
                            if (violHit) begin
                                violCnt   <= '0;
                                hdrCnt    <= '0;
                                slipCount <= '0;
                            end else begin
                                violCnt <= violCnt + 1'b1;
                            end
                        end else begin
                            gapCnt <= gapCnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Sticky flags: a new setting event outranks a simultaneous clear.
            if (cfgBad || overflow) configError <= 1'b1;
            else if (clrError)      configError <= 1'b0;
            if (lockDrop)           lockLost <= 1'b1;
            else if (clrError)      lockLost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_etroc_frame_gearbox.sv
// Directed bench for etroc_frame_gearbox: serial bit stream driver, frame capture and
// per-scenario checks against hand-built source frames.
module tb_etroc_frame_gearbox;

    localparam int IN_W    = 32;
    localparam int FRAME_W = 40;
    localparam logic [FRAME_W-1:0] HDR_FRAME = {16'h3C5C, 24'h000000};

    logic               clk40 = 1'b0;
    logic               reset;
    logic [1:0]         dataRate;
    logic [4:0]         trigDataSize;
    logic [IN_W-1:0]    din;
    logic               clrError;
    logic               autoAlign;
    logic [FRAME_W-1:0] dout;
    logic               doutValid;
    logic               aligned;
    logic [1:0]         state;
    logic [7:0]         slipCount;
    logic               configError;
    logic               lockLost;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit                 bitQ[$];
    logic [FRAME_W-1:0] rx[$];
    int                 rxCycle[$];
    logic [FRAME_W-1:0] exp_q[$];

    etroc_frame_gearbox dut (
        .clk40       (clk40),
        .reset       (reset),
        .dataRate    (dataRate),
        .trigDataSize(trigDataSize),
        .din         (din),
        .clrError    (clrError),
        .autoAlign   (autoAlign),
        .dout        (dout),
        .doutValid   (doutValid),
        .aligned     (aligned),
        .state       (state),
        .slipCount   (slipCount),
        .configError (configError),
        .lockLost    (lockLost)
    );

    always #10 clk40 = ~clk40;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1);
    end

    function automatic logic [FRAME_W-1:0] mkData(input int k);
        return {8'(k * 37 + 5), 32'(k * 32'h9E3779B1)};
    endfunction

    function automatic logic [FRAME_W-1:0] getRx(input int idx);
        if (idx < rx.size()) return rx[idx];
        return 'x;
    endfunction

    task automatic pushFrame(input logic [FRAME_W-1:0] f);
        for (int i = 0; i < FRAME_W; i++) bitQ.push_back(f[i]);
    endtask

    // Payload bits come from the stream queue; trigger and unused upper bits get noise.
    task automatic driveWord();
        int rw, pw;
        logic [IN_W-1:0] w;
        rw = (dataRate == 2'b00) ? 8 : (dataRate == 2'b01) ? 16 : 32;
        pw = (int'(trigDataSize) >= rw) ? 0 : rw - int'(trigDataSize);
        w = $urandom;
        for (int i = 0; i < pw; i++) begin
            if (bitQ.size() > 0) w[i] = bitQ.pop_front();
            else                 w[i] = 1'b0;
        end
        din = w;
    endtask

    task automatic tick();
        driveWord();
        @(posedge clk40);
        #1;
        cycle++;
        if (doutValid === 1'b1) begin
            rx.push_back(dout);
            rxCycle.push_back(cycle);
        end
    endtask

    task automatic runUntilRx(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (rx.size() < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (rx.size() < target) begin
            errors++;
            $display("FAIL %s timeout frames %0d need %0d", name, rx.size(), target);
        end
    endtask

    task automatic startTest(input logic [1:0] rate, input logic [4:0] trig, input logic align);
        reset = 1'b0;
        #2;
        dataRate     = rate;
        trigDataSize = trig;
        autoAlign    = align;
        clrError     = 1'b0;
        din          = '0;
        bitQ.delete();
        rx.delete();
        rxCycle.delete();
        exp_q.delete();
        cycle = 0;
        @(negedge clk40);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        dataRate     = 2'b10;
        trigDataSize = 5'd0;
        autoAlign    = 1'b1;
        clrError     = 1'b0;
        din          = '0;
        #35;
        checks++; if (dout !== '0)        begin errors++; $display("FAIL reset_dout got %h want 0", dout); end
        checks++; if (doutValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", doutValid); end
        checks++; if (aligned !== 1'b0)   begin errors++; $display("FAIL reset_aligned got %b want 0", aligned); end
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (slipCount !== 8'd0) begin errors++; $display("FAIL reset_slips got %0d want 0", slipCount); end
        checks++; if (configError !== 1'b0) begin errors++; $display("FAIL reset_cfgerr got %b want 0", configError); end
        checks++; if (lockLost !== 1'b0)  begin errors++; $display("FAIL reset_locklost got %b want 0", lockLost); end
    endtask

    // 17-bit offset stream at 32 b/cycle: 17 slips, lock on the 4th aligned header.
    task automatic test_align();
        logic [FRAME_W-1:0] f;
        startTest(2'b10, 5'd0, 1'b1);
        for (int i = 0; i < 17; i++) bitQ.push_back(1'b0);
        for (int k = 0; k < 29; k++) begin
            f = (k < 21) ? HDR_FRAME : mkData(k);
            pushFrame(f);
            if (k >= 17) exp_q.push_back(f);
        end
        runUntilRx(17, 200, "align_hunt");
        checks++; if (state !== 2'd0)      begin errors++; $display("FAIL align_hunt_state got %0d want 0", state); end
        checks++; if (slipCount !== 8'd17) begin errors++; $display("FAIL align_slips got %0d want 17", slipCount); end
        runUntilRx(18, 20, "align_verify");
        checks++; if (state !== 2'd1)      begin errors++; $display("FAIL align_verify_state got %0d want 1", state); end
        runUntilRx(20, 20, "align_prelock");
        checks++; if (aligned !== 1'b0)    begin errors++; $display("FAIL align_prelock got %b want 0", aligned); end
        runUntilRx(21, 20, "align_lock");
        checks++; if (state !== 2'd2)      begin errors++; $display("FAIL align_lock_state got %0d want 2", state); end
        checks++; if (aligned !== 1'b1)    begin errors++; $display("FAIL align_aligned got %b want 1", aligned); end
        runUntilRx(29, 50, "align_data");
        for (int k = 17; k < 29; k++) begin
            f = exp_q.pop_front();
            checks++;
            if (getRx(k) !== f) begin
                errors++;
                $display("FAIL align_frame%0d got %h want %h", k, getRx(k), f);
            end
        end
        checks++; if (slipCount !== 8'd17) begin errors++; $display("FAIL align_slips_held got %0d want 17", slipCount); end
    endtask

    task automatic test_async_reset();
        #4;
        reset = 1'b0;
        #1;
        checks++; if (dout !== '0)        begin errors++; $display("FAIL areset_dout got %h want 0", dout); end
        checks++; if (doutValid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", doutValid); end
        checks++; if (aligned !== 1'b0)   begin errors++; $display("FAIL areset_aligned got %b want 0", aligned); end
        checks++; if (slipCount !== 8'd0) begin errors++; $display("FAIL areset_slips got %0d want 0", slipCount); end
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL areset_state got %0d want 0", state); end
    endtask

    // 8-bit rate with 3 trigger bits: 5 payload bits/cycle, one frame every 8 cycles.
    task automatic test_rate8();
        logic [FRAME_W-1:0] f;
        int d;
        startTest(2'b00, 5'd3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            f = mkData(100 + k);
            pushFrame(f);
            exp_q.push_back(f);
        end
        runUntilRx(6, 100, "rate8");
        for (int k = 0; k < 6; k++) begin
            f = exp_q.pop_front();
            checks++;
            if (getRx(k) !== f) begin errors++; $display("FAIL rate8_frame%0d got %h want %h", k, getRx(k), f); end
        end
        for (int k = 1; k < 6; k++) begin
            d = (k < rxCycle.size()) ? rxCycle[k] - rxCycle[k-1] : -1;
            checks++;
            if (d !== 8) begin errors++; $display("FAIL rate8_gap%0d got %0d want 8", k, d); end
        end
        checks++; if (configError !== 1'b0) begin errors++; $display("FAIL rate8_cfgerr got %b want 0", configError); end
    endtask

    // Lock at 16 b/cycle, then 192 non-header frames (3 gap windows) drop lock.
    task automatic test_unlock();
        startTest(2'b01, 5'd4, 1'b0);
        for (int k = 0; k < 4; k++) pushFrame(HDR_FRAME | FRAME_W'(k));
        runUntilRx(4, 100, "unlock_lock");
        checks++; if (state !== 2'd2)    begin errors++; $display("FAIL unlock_locked got %0d want 2", state); end
        runUntilRx(195, 800, "unlock_edge");
        checks++; if (state !== 2'd2)    begin errors++; $display("FAIL unlock_still_locked got %0d want 2", state); end
        checks++; if (lockLost !== 1'b0) begin errors++; $display("FAIL unlock_early_lost got %b want 0", lockLost); end
        runUntilRx(196, 20, "unlock_drop");
        checks++; if (state !== 2'd0)    begin errors++; $display("FAIL unlock_state got %0d want 0", state); end
        checks++; if (lockLost !== 1'b1) begin errors++; $display("FAIL unlock_lost got %b want 1", lockLost); end
        checks++; if (aligned !== 1'b0)  begin errors++; $display("FAIL unlock_aligned got %b want 0", aligned); end
        clrError = 1'b1;
        tick();
        clrError = 1'b0;
        checks++; if (lockLost !== 1'b0) begin errors++; $display("FAIL unlock_clear got %b want 0", lockLost); end
    endtask

    // Rate change in a cycle that would otherwise emit: strobe suppressed, relock at new rate.
    task automatic test_rate_change();
        logic [FRAME_W-1:0] f;
        startTest(2'b10, 5'd0, 1'b1);
        for (int k = 0; k < 12; k++) pushFrame(HDR_FRAME | FRAME_W'(k + 1));
        runUntilRx(6, 50, "rchg_pre");
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rchg_pre_state got %0d want 2", state); end
        dataRate = 2'b01;
        bitQ.delete();
        for (int k = 0; k < 8; k++) begin
            f = HDR_FRAME | FRAME_W'(24'hA00000 + k);
            pushFrame(f);
            exp_q.push_back(f);
        end
        tick();
        checks++; if (doutValid !== 1'b0) begin errors++; $display("FAIL rchg_flush_valid got %b want 0", doutValid); end
        checks++; if (state !== 2'd0)     begin errors++; $display("FAIL rchg_flush_state got %0d want 0", state); end
        rx.delete();
        rxCycle.delete();
        runUntilRx(6, 100, "rchg_relock");
        for (int k = 0; k < 6; k++) begin
            f = exp_q.pop_front();
            checks++;
            if (getRx(k) !== f) begin errors++; $display("FAIL rchg_frame%0d got %h want %h", k, getRx(k), f); end
        end
        checks++; if (state !== 2'd2)     begin errors++; $display("FAIL rchg_relock_state got %0d want 2", state); end
        checks++; if (slipCount !== 8'd0) begin errors++; $display("FAIL rchg_slips got %0d want 0", slipCount); end
    endtask

    task automatic test_config_error();
        logic [FRAME_W-1:0] f;
        startTest(2'b00, 5'd10, 1'b0);
        for (int n = 0; n < 30; n++) tick();
        checks++; if (rx.size() !== 0)      begin errors++; $display("FAIL cfg_no_valid got %0d want 0", rx.size()); end
        checks++; if (configError !== 1'b1) begin errors++; $display("FAIL cfg_set got %b want 1", configError); end
        trigDataSize = 5'd2;
        for (int k = 0; k < 4; k++) begin
            f = mkData(200 + k);
            pushFrame(f);
            exp_q.push_back(f);
        end
        runUntilRx(4, 100, "cfg_resume");
        for (int k = 0; k < 4; k++) begin
            f = exp_q.pop_front();
            checks++;
            if (getRx(k) !== f) begin errors++; $display("FAIL cfg_frame%0d got %h want %h", k, getRx(k), f); end
        end
        checks++; if (configError !== 1'b1) begin errors++; $display("FAIL cfg_sticky got %b want 1", configError); end
        clrError = 1'b1;
        tick();
        clrError = 1'b0;
        checks++; if (configError !== 1'b0) begin errors++; $display("FAIL cfg_clear got %b want 0", configError); end
    endtask

    initial begin
        test_reset();
        test_align();
        test_async_reset();
        test_rate8();
        test_unlock();
        test_rate_change();
        test_config_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/etroc_frame_gearbox.md
Name: etroc_frame_gearbox

Overview:
- Parametrised successor to the ETROC2 link data extractor.
- Accepts the per-clk40 deserialised word at 8/16/32-bit link rates and strips the trigger bits.
- Accumulates payload bits in a circular bit buffer and emits FRAME_W-bit frames with a one-cycle valid strobe.
- Performs autonomous bit-slip frame alignment against a configurable header pattern, with lock/unlock hysteresis. Sits between the link deserialiser and the event builder.

Parameters:
- IN_W, 32, widest input word in bits; must be ≥32.
- FRAME_W, 40, output frame width in bits.
- BUF_W, 256, circular buffer depth in bits; power of 2, ≥ 2*(FRAME_W+IN_W).
- HDR_W, 16, header pattern width.
- HDR_PATTERN, 16'h3C5C, header/idle signature in frame bits [FRAME_W-1 -: HDR_W].
- LOCK_CNT, 4, header-class frames needed to declare lock.
- MAX_GAP, 64, maximum frames allowed between header-class frames.
- UNLOCK_CNT, 3, consecutive gap violations that drop lock.

Ports:
- clk40  in  1  40 MHz clock.
- reset  in  1  asynchronous, active-low reset.
- dataRate  in  2  00 = 8 b, 01 = 16 b, 1x = 32 b per cycle.
- trigDataSize  in  5  trigger bits per word (MSBs of the active width), 0..16.
- din  in  IN_W  deserialised word, LSB = earliest payload bit.
- clrError  in  1  synchronous clear of the sticky error flags.
- autoAlign  in  1  1 = bit-slips allowed in HUNT.
- dout  out  FRAME_W  aligned frame.
- doutValid  out  1  one-cycle strobe per frame.
- aligned  out  1  FSM in LOCKED.
- state  out  2  FSM state.
- slipCount  out  8  bit slips since last lock, saturating.
- configError  out  1  sticky error flag.
- lockLost  out  1  sticky error flag.

Behaviour:
- **Reset:** all outputs, pointers, the fill counter and all counters reset to 0; FSM resets to HUNT.
- **Payload width:**
  - rateW = 8/16/32 per dataRate; W = rateW − trigDataSize.
  - If trigDataSize > rateW or W == 0: no buffer writes and configError is set (sticky).
  - Payload is din[W-1:0]; bits [rateW-1:W] are ignored.
- **Input register:** din is registered once before the buffer write (1 cycle).
- **Write side:**
  - Each cycle, write W bits at wrPtr (mod BUF_W), then wrPtr += W.
  - fill counter is log2(BUF_W)+1 bits wide.
- **Frame emit:**
  - Condition: fill ≥ FRAME_W + slipPend (slipPend ∈ {0,1}).
  - On emit: frame bit i = buf[(rdPtr+slipPend+i) mod BUF_W]; rdPtr += FRAME_W+slipPend; fill += W − FRAME_W − slipPend; slipPend clears.
  - dout and doutValid are registered 1 cycle after the emit decision, so latency din→dout is ≥ 2 cycles.
  - dout holds its value between strobes.
- **Simultaneous write and read:** in the same cycle, both the write and the read use pre-update pointers.
- **Config change:** any change of dataRate or trigDataSize flushes the pipeline the next cycle: fill = 0, wrPtr = rdPtr = 0, slipPend = 0, FSM → HUNT, no doutValid that cycle.
- **Overflow guard:** if fill would exceed BUF_W − IN_W, flush as for a config change and set configError.
- **Header-class frame:** frame bits [FRAME_W-1 -: HDR_W] == HDR_PATTERN.
- **FSM states:** HUNT = 0, VERIFY = 1, LOCKED = 2.
  - HUNT:
    - A header-class frame → VERIFY with hdrCnt = 1 and gapCnt = 0.
    - Any other frame with autoAlign = 1 → slipPend = 1 and slipCount++.
  - VERIFY:
    - A header-class frame → hdrCnt++ and gapCnt = 0.
    - hdrCnt reaching LOCK_CNT → LOCKED, slipCount held.
    - gapCnt reaching MAX_GAP → HUNT.
  - LOCKED:
    - gapCnt reaching MAX_GAP → violCnt++ and gapCnt = 0.
    - A header-class frame → violCnt = 0.
    - violCnt reaching UNLOCK_CNT → HUNT, lockLost set (sticky), slipCount = 0.
- **Counter rules:** gapCnt increments on each non-header-class frame. Counters only change on emit cycles.
- **Sticky-flag priority:** clrError clears configError and lockLost unless the setting condition occurs in the same cycle; set wins.
- **Asynchronous reset mid-frame:** immediate return to the reset values; the partial frame is discarded.

Test Plan:
- 32-bit rate, trigDataSize = 0, serial stream of 40-bit frames (header 0x3C5C0xxxxx then data) with 17-bit offset → exactly 17 slips, aligned after LOCK_CNT = 4 headers, all subsequent dout match the source frames.
- 8-bit rate, trigDataSize = 3 (W = 5) → one doutValid every 8 cycles, frame content bit-exact, no configError.
- Lock at 16-bit/trig = 4, then corrupt headers for 3×MAX_GAP frames → state returns to HUNT, lockLost = 1; clrError → lockLost = 0.
- Change dataRate mid-stream → doutValid suppressed on the flush cycle, fill = 0, state = HUNT, relock on the new rate.
- trigDataSize = 10 at 8-bit rate → configError = 1, no doutValid; restore trigDataSize = 2 → frames resume, configError stays 1 until clrError.
- Assert reset asynchronously between clock edges while LOCKED → dout = 0, doutValid = 0, aligned = 0, slipCount = 0 immediately.
